// File: rtl/tinyqv_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tinyqv_irq_ctrl
//
// Interrupt controller for a nibble-serial RISC-V core. CSRs are transferred
// four bits at a time: on every clock the core presents nibble `counter` of a
// 32-bit CSR. Reads return that nibble combinationally. Writes commit on the
// same clock edge.
//
// CSR map:
//   0x304 mie : bit 7 = timer enable, bit 16+i = source i enable
//   0x344 mip : bit 7 = timer_irq (read-only), bit 16+i = source i pending
//   0x7C0 edge: bit i = 1 -> source i is edge-triggered, 0 -> level
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   counter           nibble index 0..7 of the current CSR beat
//   csr_addr/op/wdata CSR access (op: 00 none, 01 write, 10 set, 11 clear)
//   csr_rdata         current nibble of the addressed CSR (0 if unmapped)
//   irq_in            external request lines
//   timer_irq         timer request, always level
//   global_ie         mstatus.MIE from the core
//   irq_ack           core takes the interrupt this cycle
//   interrupt_pending global_ie AND any enabled pending source
//   mcause_code       cause of the last acknowledged interrupt (registered)
// -----------------------------------------------------------------------------
module tinyqv_irq_ctrl #(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_RESET = 4'b0011
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         counter,
    input  logic [11:0]        csr_addr,
    input  logic [1:0]         csr_op,
    input  logic [3:0]         csr_wdata,
    output logic [3:0]         csr_rdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               timer_irq,
    input  logic               global_ie,
    input  logic               irq_ack,
    output logic               interrupt_pending,
    output logic [4:0]         mcause_code
);

    localparam logic [11:0] ADDR_MIE  = 12'h304;
    localparam logic [11:0] ADDR_MIP  = 12'h344;
    localparam logic [11:0] ADDR_EDGE = 12'h7C0;

    logic               mie_timer_r;
    logic [NUM_IRQ-1:0] mie_irq_r;
    logic [NUM_IRQ-1:0] pend_r;
    logic [NUM_IRQ-1:0] edge_mode_r;
    logic [NUM_IRQ-1:0] last_irq_r;
    logic [4:0]         mcause_r;

    logic [31:0]        mie_word_s;
    logic [31:0]        mip_word_s;
    logic [31:0]        edge_word_s;
    logic [31:0]        active_s;
    logic [31:0]        sel_word_s;
    logic [31:0]        new_word_s;
    logic               hit_s;
    logic [4:0]         nib_lsb_s;
    logic [3:0]         cur_nibble_s;
    logic [3:0]         new_nibble_s;
    logic               wr_en_s;
    logic               mie_we_s;
    logic               mip_we_s;
    logic               edge_we_s;
    logic [NUM_IRQ-1:0] src_active_s;
    logic [NUM_IRQ-1:0] src_first_s;
    logic [4:0]         src_code_s;
    logic [4:0]         win_code_s;
    logic [NUM_IRQ-1:0] win_src_s;
    logic               ack_take_s;
    logic [NUM_IRQ-1:0] edge_next_s;
    logic [NUM_IRQ-1:0] pend_csr_s;
    logic [NUM_IRQ-1:0] pend_ack_s;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] pend_next_s;
    logic               unused_s;

    // Assemble the architectural 32-bit views of the three CSRs.
    always_comb begin
        mie_word_s                   = 32'd0;
        mip_word_s                   = 32'd0;
        edge_word_s                  = 32'd0;
        mie_word_s[7]                = mie_timer_r;
        mie_word_s[16 +: NUM_IRQ]    = mie_irq_r;
        mip_word_s[7]                = timer_irq;
        // Edge sources show the latched pend bit, level sources the raw line.
        mip_word_s[16 +: NUM_IRQ]    = (edge_mode_r & pend_r) | (~edge_mode_r & irq_in);
        edge_word_s[NUM_IRQ-1:0]     = edge_mode_r;
    end

    assign active_s          = mip_word_s & mie_word_s;
    assign interrupt_pending = global_ie & (|active_s);
    assign nib_lsb_s         = {counter, 2'b00};

    // Address decode and selection of the word being accessed.
    always_comb begin
        sel_word_s = 32'd0;
        hit_s      = 1'b0;
        case (csr_addr)
            ADDR_MIE:  begin sel_word_s = mie_word_s;  hit_s = 1'b1; end
            ADDR_MIP:  begin sel_word_s = mip_word_s;  hit_s = 1'b1; end
            ADDR_EDGE: begin sel_word_s = edge_word_s; hit_s = 1'b1; end
            default:   begin sel_word_s = 32'd0;       hit_s = 1'b0; end
        endcase
    end

    assign cur_nibble_s = sel_word_s[nib_lsb_s +: 4];
    assign csr_rdata    = cur_nibble_s;

    // Apply the CSR operation to the selected nibble.
    always_comb begin
        new_nibble_s = cur_nibble_s;
        case (csr_op)
            2'b01:   new_nibble_s = csr_wdata;
            2'b10:   new_nibble_s = cur_nibble_s | csr_wdata;
            2'b11:   new_nibble_s = cur_nibble_s & ~csr_wdata;
            default: new_nibble_s = cur_nibble_s;
        endcase
    end

    // Splice the updated nibble back into the word; fields pick their bits out.
    always_comb begin
        new_word_s                   = sel_word_s;
        new_word_s[nib_lsb_s +: 4]   = new_nibble_s;
    end

    assign wr_en_s   = hit_s & (csr_op != 2'b00);
    assign mie_we_s  = wr_en_s & (csr_addr == ADDR_MIE);
    assign mip_we_s  = wr_en_s & (csr_addr == ADDR_MIP);
    assign edge_we_s = wr_en_s & (csr_addr == ADDR_EDGE);

    // Lowest-index active source via two's-complement isolate of the lowest set bit.
    assign src_active_s = active_s[16 +: NUM_IRQ];
    assign src_first_s  = src_active_s & (~src_active_s + NUM_IRQ'(1));

    // Fixed priority: timer first, then source 0 upwards.
    always_comb begin
        src_code_s = 5'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            src_code_s = src_code_s | (src_first_s[i] ? 5'(16 + i) : 5'd0);
        end
        if (active_s[7]) begin
            win_code_s = 5'd7;
            win_src_s  = '0;
        end else begin
            win_code_s = src_code_s;
            win_src_s  = src_first_s;
        end
    end

    assign ack_take_s = irq_ack & (|active_s);

    // Pend update order: CSR write, then ack clear, then hardware edge set.
    always_comb begin
        if (edge_we_s) begin
            edge_next_s = new_word_s[NUM_IRQ-1:0];
        end else begin
            edge_next_s = edge_mode_r;
        end
        // Software may only write pend bits of edge sources.
        if (mip_we_s) begin
            pend_csr_s = (new_word_s[16 +: NUM_IRQ] & edge_mode_r) | (pend_r & ~edge_mode_r);
        end else begin
            pend_csr_s = pend_r;
        end
        if (ack_take_s) begin
            pend_ack_s = pend_csr_s & ~(win_src_s & edge_mode_r);
        end else begin
            pend_ack_s = pend_csr_s;
        end
        rise_s      = irq_in & ~last_irq_r;
        // Sources that are (or become) level-mode hold pend at 0.
        pend_next_s = (pend_ack_s | rise_s) & edge_next_s;
    end

    // Architectural state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_timer_r <= 1'b0;
            mie_irq_r   <= '0;
            pend_r      <= '0;
            edge_mode_r <= EDGE_RESET;
            mcause_r    <= 5'd0;
        end else begin
            if (mie_we_s) begin
                mie_timer_r <= new_word_s[7];
                mie_irq_r   <= new_word_s[16 +: NUM_IRQ];
            end else begin
                mie_timer_r <= mie_timer_r;
                mie_irq_r   <= mie_irq_r;
            end
            pend_r      <= pend_next_s;
            edge_mode_r <= edge_next_s;
            if (ack_take_s) begin
                mcause_r <= win_code_s;
            end else begin
                mcause_r <= mcause_r;
            end
        end
    end

    // Edge-detect history keeps sampling through reset so lines already high
    // at release are not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        last_irq_r <= irq_in;
    end

    assign mcause_code = mcause_r;

    // Bits of the spliced word that no field uses.
    assign unused_s = ^new_word_s;

endmodule

// File: tb/tb_tinyqv_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tinyqv_irq_ctrl
//
// Drives tinyqv_irq_ctrl with directed scenarios and randomized CSR traffic.
// A word-level reference model (32-bit mie, per-source pend/edge arrays) is
// advanced alongside the design; every output is compared each cycle.
// -----------------------------------------------------------------------------
module tb_tinyqv_irq_ctrl;

    localparam int N = 4;
    localparam logic [N-1:0] EDGE_RST = 4'b0011;
    localparam logic [31:0]  MIE_MASK = 32'h0000_0080 | (((32'd1 << N) - 32'd1) << 16);

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   counter;
    logic [11:0]  csr_addr;
    logic [1:0]   csr_op;
    logic [3:0]   csr_wdata;
    logic [3:0]   csr_rdata;
    logic [N-1:0] irq_in;
    logic         timer_irq;
    logic         global_ie;
    logic         irq_ack;
    logic         interrupt_pending;
    logic [4:0]   mcause_code;

    tinyqv_irq_ctrl #(.NUM_IRQ(N), .EDGE_RESET(EDGE_RST)) dut (
        .clk               (clk),
        .rst               (rst),
        .counter           (counter),
        .csr_addr          (csr_addr),
        .csr_op            (csr_op),
        .csr_wdata         (csr_wdata),
        .csr_rdata         (csr_rdata),
        .irq_in            (irq_in),
        .timer_irq         (timer_irq),
        .global_ie         (global_ie),
        .irq_ack           (irq_ack),
        .interrupt_pending (interrupt_pending),
        .mcause_code       (mcause_code)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Stimulus state held by the bench
    logic [N-1:0] irq_v;
    logic         tmr_v;
    logic         gie_v;
    logic         rst_v;
    logic [2:0]   cnt_m;

    // Reference model state
    logic [31:0]  mie_m;
    logic [N-1:0] pend_m;
    logic [N-1:0] edge_m;
    logic [N-1:0] last_m;
    logic [4:0]   mcause_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mie_m    = 32'd0;
        pend_m   = '0;
        edge_m   = EDGE_RST;
        mcause_m = 5'd0;
        last_m   = irq_v;
    endtask

    function automatic logic [31:0] mip_model();
        logic [31:0] w;
        w = tmr_v ? 32'h0000_0080 : 32'd0;
        for (int i = 0; i < N; i++) begin
            if (edge_m[i] ? pend_m[i] : irq_v[i]) w = w | (32'd1 << (16 + i));
        end
        return w;
    endfunction

    function automatic logic [31:0] apply_op(input logic [31:0] old, input logic [1:0] op,
                                             input logic [3:0] wd, input logic [2:0] cnt);
        logic [31:0] nm;
        logic [31:0] wv;
        nm = 32'hF << (4 * cnt);
        wv = 32'(wd) << (4 * cnt);
        case (op)
            2'b01:   return (old & ~nm) | wv;
            2'b10:   return old | wv;
            2'b11:   return old & ~wv;
            default: return old;
        endcase
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model, check mcause.
    task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [3:0] wd,
                        input logic ack, output logic [3:0] rd);
        logic [31:0] mip, act, w, nw, ew;
        logic [N-1:0] p, e_n;
        logic [4:0]  win;
        logic        have;
        csr_addr = a; csr_op = op; csr_wdata = wd; irq_ack = ack; counter = cnt_m;
        irq_in = irq_v; timer_irq = tmr_v; global_ie = gie_v; rst = rst_v;
        #1;
        mip = mip_model();
        act = mip & mie_m;
        case (a)
            12'h304: w = mie_m;
            12'h344: w = mip;
            12'h7C0: w = 32'(edge_m);
            default: w = 32'd0;
        endcase
        check_val("rdata", 32'(csr_rdata), (w >> (4 * cnt_m)) & 32'hF);
        check_val("pending", 32'(interrupt_pending), 32'(gie_v && (act != 32'd0)));
        rd = csr_rdata;
        have = 1'b0;
        win  = 5'd0;
        if (act[7]) begin
            win = 5'd7; have = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (!have && act[16 + i]) begin
                win = 5'(16 + i); have = 1'b1;
            end
        end
        if (rst_v) begin
            model_reset();
        end else begin
            p   = pend_m;
            e_n = edge_m;
            if (op != 2'b00) begin
                if (a == 12'h304) mie_m = apply_op(mie_m, op, wd, cnt_m) & MIE_MASK;
                if (a == 12'h344) begin
                    nw = apply_op(mip, op, wd, cnt_m);
                    for (int i = 0; i < N; i++) if (edge_m[i]) p[i] = nw[16 + i];
                end
                if (a == 12'h7C0) begin
                    ew  = apply_op(32'(edge_m), op, wd, cnt_m);
                    e_n = ew[N-1:0];
                end
            end
            if (ack && have) begin
                mcause_m = win;
                if (win >= 5'd16 && edge_m[win - 5'd16]) p[win - 5'd16] = 1'b0;
            end
            for (int i = 0; i < N; i++) if (irq_v[i] && !last_m[i]) p[i] = 1'b1;
            pend_m = p & e_n;
            edge_m = e_n;
            last_m = irq_v;
        end
        @(posedge clk);
        @(negedge clk);
        check_val("mcause", 32'(mcause_code), 32'(mcause_m));
        cnt_m = cnt_m + 3'd1;
    endtask

    task automatic idle_to(input logic [2:0] target);
        logic [3:0] nib;
        while (cnt_m != target) step(12'h000, 2'b00, 4'h0, 1'b0, nib);
    endtask

    // Full 32-bit CSR access over eight nibble beats; returns pre-write value.
    task automatic csr32(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                         output logic [31:0] rd_word);
        logic [3:0]  nib;
        logic [31:0] dd;
        idle_to(3'd0);
        rd_word = 32'd0;
        for (int n = 0; n < 8; n++) begin
            dd = d >> (4 * n);
            step(a, op, dd[3:0], 1'b0, nib);
            rd_word[4 * n +: 4] = nib;
        end
    endtask

    initial begin
        logic [31:0] word;
        logic [3:0]  nib;
        logic [31:0] rv;

        irq_v = '0; tmr_v = 1'b0; gie_v = 1'b0; rst_v = 1'b1; cnt_m = 3'd0;
        rst = 1'b1; counter = 3'd0; csr_addr = 12'h000; csr_op = 2'b00; csr_wdata = 4'h0;
        irq_in = '0; timer_irq = 1'b0; global_ie = 1'b0; irq_ack = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state: edge register reads its reset value, nothing pending
        for (int k = 0; k < 3; k++) step(12'h7C0, 2'b00, 4'h0, 1'b0, nib);
        check_val("reset_mcause", 32'(mcause_code), 32'd0);
        rst_v = 1'b0;
        step(12'h000, 2'b00, 4'h0, 1'b0, nib);

        // CSR write/clear/set sequence and edge-mode masking
        csr32(12'h304, 2'b01, 32'h0007_0080, word);
        csr32(12'h304, 2'b11, 32'h0001_0000, word);
        csr32(12'h304, 2'b10, 32'h0008_0000, word);
        csr32(12'h304, 2'b00, 32'h0, word);
        check_val("mie_ops", word, 32'h000E_0080);
        csr32(12'h7C0, 2'b01, 32'hFFFF_FFFF, word);
        csr32(12'h7C0, 2'b00, 32'h0, word);
        check_val("edge_mask", word, 32'h0000_000F);

        // Level priority: timer over sources, then source 0
        csr32(12'h7C0, 2'b01, 32'h0, word);
        irq_v = 4'b0101; tmr_v = 1'b1; gie_v = 1'b1;
        csr32(12'h304, 2'b01, 32'h0005_0080, word);
        check_val("lvl_pending", 32'(interrupt_pending), 32'd1);
        step(12'h000, 2'b00, 4'h0, 1'b1, nib);
        check_val("lvl_timer", 32'(mcause_code), 32'd7);
        tmr_v = 1'b0;
        step(12'h000, 2'b00, 4'h0, 1'b1, nib);
        check_val("lvl_src0", 32'(mcause_code), 32'd16);

        // Edge latch and acknowledge on source 1
        irq_v = '0;
        csr32(12'h7C0, 2'b01, 32'h2, word);
        csr32(12'h304, 2'b01, 32'h0002_0000, word);
        irq_v = 4'b0010;
        step(12'h000, 2'b00, 4'h0, 1'b0, nib);
        irq_v = 4'b0000;
        csr32(12'h344, 2'b00, 32'h0, word);
        check_val("edge_latched", word, 32'h0002_0000);
        step(12'h000, 2'b00, 4'h0, 1'b1, nib);
        check_val("edge_ack_cause", 32'(mcause_code), 32'd17);
        csr32(12'h344, 2'b00, 32'h0, word);
        check_val("edge_cleared", word, 32'h0);
        check_val("edge_no_pend", 32'(interrupt_pending), 32'd0);

        // Hardware set wins over simultaneous software clear
        csr32(12'h7C0, 2'b01, 32'h1, word);
        irq_v = 4'b0001;
        step(12'h000, 2'b00, 4'h0, 1'b0, nib);
        irq_v = 4'b0000;
        idle_to(3'd4);
        irq_v = 4'b0001;
        step(12'h344, 2'b11, 4'h1, 1'b0, nib);
        csr32(12'h344, 2'b00, 32'h0, word);
        check_val("set_wins", (word >> 16) & 32'h1, 32'd1);
        irq_v = 4'b0000;

        // Global enable gating is combinational
        csr32(12'h304, 2'b01, 32'h0000_0080, word);
        tmr_v = 1'b1; gie_v = 1'b0;
        step(12'h000, 2'b00, 4'h0, 1'b0, nib);
        check_val("gie_off", 32'(interrupt_pending), 32'd0);
        gie_v = 1'b1; global_ie = 1'b1;
        #1;
        check_val("gie_on", 32'(interrupt_pending), 32'd1);
        tmr_v = 1'b0;

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [11:0] a;
            rv = $urandom;
            case (rv[1:0])
                2'd0:    a = 12'h304;
                2'd1:    a = 12'h344;
                2'd2:    a = 12'h7C0;
                default: a = rv[31:20];
            endcase
            for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) irq_v[i] = ~irq_v[i];
            if ($urandom_range(0, 7) == 0) tmr_v = ~tmr_v;
            gie_v = ($urandom_range(0, 7) != 0);
            step(a, rv[3:2], rv[7:4], ($urandom_range(0, 3) == 0), nib);
        end

        // Asynchronous reset in the middle of a write, inputs held high
        gie_v = 1'b1; tmr_v = 1'b0; irq_v = '1;
        idle_to(3'd0);
        for (int n = 0; n < 5; n++) step(12'h304, 2'b01, 4'hF, 1'b0, nib);
        csr_addr = 12'h304; csr_op = 2'b01; csr_wdata = 4'hF; irq_ack = 1'b0; counter = cnt_m;
        irq_in = irq_v; timer_irq = tmr_v; global_ie = gie_v;
        #2;
        check_val("pre_rst_pending", 32'(interrupt_pending), 32'd1);
        rst_v = 1'b1; rst = 1'b1;
        #1;
        model_reset();
        check_val("async_rdata", 32'(csr_rdata), 32'd0);
        check_val("async_pending", 32'(interrupt_pending), 32'd0);
        check_val("async_mcause", 32'(mcause_code), 32'd0);
        @(posedge clk);
        @(negedge clk);
        cnt_m = cnt_m + 3'd1;
        for (int k = 0; k < 3; k++) step(12'h304, 2'b00, 4'h0, 1'b0, nib);
        rst_v = 1'b0;
        for (int k = 0; k < 3; k++) step(12'h000, 2'b00, 4'h0, 1'b0, nib);
        csr32(12'h344, 2'b00, 32'h0, word);
        check_val("no_edge_after_rst", word, 32'h000C_0000);
        csr32(12'h304, 2'b00, 32'h0, word);
        check_val("mie_lost", word, 32'h0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
